// File: rtl/seg7_multi_ctrl.sv
// Avalon-MM seven-segment controller for NUM_DIGITS digits. It provides hex decode, per-digit enable,
// decimal points, per-digit blink with a programmable timebase, global blank and byte-lane writes.
module seg7_multi_ctrl #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter logic [31:0] BLINK_DIV_RST = 32'd25000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [3:0]              byteenable,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [8*NUM_DIGITS-1:0] seg_out
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned SW = 8 * NUM_DIGITS;

    typedef enum logic [2:0] {
        A_DATA   = 3'd0,
        A_ENABLE = 3'd1,
        A_BLINK  = 3'd2,
        A_DP     = 3'd3,
        A_CTRL   = 3'd4,
        A_DIV    = 3'd5
    } reg_addr_e;

    logic [DW-1:0]         data_q, data_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic [NUM_DIGITS-1:0] blink_q, blink_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic                  ctrl_q, ctrl_d;
    logic [31:0]           div_q, div_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [SW-1:0]         seg_q, seg_d;

    logic                  wr_en;
    logic                  div_wr;
    logic [31:0]           merged;
    logic [31:0]           data_w, en_w, blink_w, dp_w;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = cur;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        data_w  = '0;
        en_w    = '0;
        blink_w = '0;
        dp_w    = '0;
        data_w[DW-1:0]          = data_q;
        en_w[NUM_DIGITS-1:0]    = en_q;
        blink_w[NUM_DIGITS-1:0] = blink_q;
        dp_w[NUM_DIGITS-1:0]    = dp_q;
    end

    always_comb begin
        readdata = '0;
        case (address)
            A_DATA:   readdata = data_w;
            A_ENABLE: readdata = en_w;
            A_BLINK:  readdata = blink_w;
            A_DP:     readdata = dp_w;
            A_CTRL:   readdata = {31'd0, ctrl_q};
            A_DIV:    readdata = div_q;
            default:  readdata = '0;
        endcase
    end

    // The addressed register's current value is exactly readdata, so lane merging starts from it.
    assign wr_en  = chipselect & ~write_n;
    assign merged = lane_merge(readdata, writedata, byteenable);
    assign div_wr = wr_en && (address == A_DIV);

    always_comb begin
        data_d  = data_q;
        en_d    = en_q;
        blink_d = blink_q;
        dp_d    = dp_q;
        ctrl_d  = ctrl_q;
        div_d   = div_q;
        if (wr_en) begin
            case (address)
                A_DATA:   data_d  = merged[DW-1:0];
                A_ENABLE: en_d    = merged[NUM_DIGITS-1:0];
                A_BLINK:  blink_d = merged[NUM_DIGITS-1:0];
                A_DP:     dp_d    = merged[NUM_DIGITS-1:0];
                A_CTRL:   ctrl_d  = merged[0];
                A_DIV:    div_d   = merged;
                default:  ;
            endcase
        end
    end

    // A BLINK_DIV write restarts the half-period and wins over a terminal-count reload.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_wr) begin
            cnt_d   = merged;
            phase_d = 1'b1;
        end else if (div_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = div_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 32'd1;
        end
    end

    always_comb begin
        logic [SW-1:0] raw;
        logic          vis;
        raw = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            vis = en_q[i] & ~ctrl_q & (~blink_q[i] | phase_q);
            if (vis) raw[8*i +: 8] = {dp_q[i], hex_decode(data_q[4*i +: 4])};
        end
        seg_d = ACTIVE_LOW ? ~raw : raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            en_q    <= '1;
            blink_q <= '0;
            dp_q    <= '0;
            ctrl_q  <= 1'b0;
            div_q   <= BLINK_DIV_RST;
            cnt_q   <= BLINK_DIV_RST;
            phase_q <= 1'b1;
            seg_q   <= {SW{ACTIVE_LOW}};
        end else begin
            data_q  <= data_d;
            en_q    <= en_d;
            blink_q <= blink_d;
            dp_q    <= dp_d;
            ctrl_q  <= ctrl_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign seg_out = seg_q;

endmodule

// File: tb/tb_seg7_multi_ctrl.sv
// Directed bench for seg7_multi_ctrl (6 digits, active-low). The reference model predicts readdata
// and seg_out on every cycle; phase is derived from the elapsed time since the last timebase reload.
module tb_seg7_multi_ctrl;

    localparam int unsigned ND  = 6;
    localparam logic [31:0] RST = 32'd25000000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [3:0]    byteenable;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [8*ND-1:0] seg_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    seg7_multi_ctrl #(
        .NUM_DIGITS(ND),
        .ACTIVE_LOW(1'b1),
        .BLINK_DIV_RST(RST)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .byteenable(byteenable),
        .writedata(writedata),
        .readdata(readdata),
        .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [31:0]     m_reg [8];
    longint unsigned m_n;
    logic [8*ND-1:0] exp_seg;
    bit              model_ok = 0;
    logic [7:0]      seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    function automatic logic [31:0] field_mask(input int a);
        case (a)
            0: return 32'h00FF_FFFF;
            1, 2, 3: return 32'h0000_003F;
            4: return 32'h0000_0001;
            5: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_phase();
        longint unsigned half;
        if (m_reg[5] == 0) return 1'b1;
        half = longint'(m_reg[5]) + 1;
        return ((m_n / half) % 2) == 0;
    endfunction

    function automatic logic [8*ND-1:0] m_display();
        logic [8*ND-1:0] s;
        bit ph;
        ph = m_phase();
        s = '1;
        for (int i = 0; i < ND; i++) begin
            if (m_reg[1][i] && !m_reg[4][0] && (!m_reg[2][i] || ph)) begin
                logic [7:0] on;
                on = {m_reg[3][i], seg_tab[(m_reg[0] >> (4*i)) & 32'hF][6:0]};
                s[8*i +: 8] = ~on;
            end
        end
        return s;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg[0] = 0; m_reg[1] = 32'h3F; m_reg[2] = 0; m_reg[3] = 0;
            m_reg[4] = 0; m_reg[5] = RST;    m_reg[6] = 0; m_reg[7] = 0;
            m_n      = 0;
            exp_seg  = '1;
            model_ok = 1;
        end else begin
            exp_seg = m_display();
            m_n++;
            if (chipselect && !write_n && address < 6) begin
                logic [31:0] v;
                v = m_reg[address];
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) v[8*b +: 8] = writedata[8*b +: 8];
                m_reg[address] = v & field_mask(int'(address));
                if (address == 5) m_n = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("seg_model", seg_out, exp_seg);
            chk("rd_model", readdata, (address < 6) ? m_reg[address] : 32'h0);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk); #2;
        address = a; writedata = d; byteenable = be; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic wr_nocs(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); #2;
        address = a; writedata = d; byteenable = 4'hF; chipselect = 1'b0; write_n = 1'b0;
        @(negedge clk); #2;
        write_n = 1'b1;
    endtask

    task automatic seg_next(input string name, input logic [8*ND-1:0] exp);
        @(negedge clk); #1;
        chk(name, seg_out, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        byteenable = '0; writedata = '0;
        repeat (3) @(negedge clk);
        #1 chk("reset_seg", seg_out, 48'hFFFF_FFFF_FFFF);
        address = 3'd1; #1 chk("reset_enable", readdata, 32'h3F);
        address = 3'd5; #1 chk("reset_div", readdata, RST);
        #1 reset_n = 1'b1;
        seg_next("post_reset_zeros", 48'hC0C0_C0C0_C0C0);

        wr(3'd0, 32'h00A5_4321, 4'b0011);
        chk("data_lanes", readdata, 32'h0000_4321);
        seg_next("digits_1234", 48'hC0C0_99B0_A4F9);

        wr(3'd3, 32'h1, 4'hF);
        wr(3'd1, 32'h3E, 4'hF);
        seg_next("digit0_hidden_dp", 48'hC0C0_99B0_A4FF);
        wr(3'd4, 32'h1, 4'hF);
        seg_next("global_blank", 48'hFFFF_FFFF_FFFF);
        wr(3'd4, 32'h0, 4'hF);
        seg_next("blank_off", 48'hC0C0_99B0_A4FF);

        wr(3'd5, 32'd3, 4'hF);
        wr(3'd2, 32'h04, 4'hF);
        seg_next("blink_visible", 48'hC0C0_99B0_A4FF);
        repeat (2) @(negedge clk);
        #1 chk("blink_hidden", seg_out, 48'hC0C0_99FF_A4FF);

        wr(3'd5, 32'd0, 4'b0001);
        seg_next("div0_visible", 48'hC0C0_99B0_A4FF);
        repeat (10) @(negedge clk);
        #1 chk("div0_steady", seg_out, 48'hC0C0_99B0_A4FF);

        wr(3'd5, 32'd5, 4'hF);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_seg", seg_out, 48'hFFFF_FFFF_FFFF);
        address = 3'd5; #1 chk("async_reset_div", readdata, RST);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        seg_next("after_reset_zeros", 48'hC0C0_C0C0_C0C0);

        wr(3'd6, 32'hFFFF_FFFF, 4'hF);
        wr_nocs(3'd0, 32'h0012_3456);
        wr_nocs(3'd4, 32'h1);
        begin
            logic [31:0] rv [8];
            rv = '{32'h0, 32'h3F, 32'h0, 32'h0, 32'h0, RST, 32'h0, 32'h0};
            for (int a = 0; a < 8; a++) begin
                address = 3'(a); #1;
                chk($sformatf("readback_%0d", a), readdata, rv[a]);
            end
        end
        seg_next("no_write_effect", 48'hC0C0_C0C0_C0C0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
